// File: rtl/sad_absdiff_accumulator_if.sv
// Pixel-pair input and SAD result handshakes for sad_absdiff_accumulator.
// The slave modport is the accumulator side; master is the producer/consumer side.
interface sad_absdiff_accumulator_if #(
    parameter int unsigned ACC_W = 12
);
    logic [7:0]       a;
    logic [7:0]       b;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] sad;
    logic             sad_valid;
    logic             sad_ready;

    modport master (
        output a, b, in_valid, sad_ready,
        input  in_ready, sad, sad_valid
    );

    modport slave (
        input  a, b, in_valid, sad_ready,
        output in_ready, sad, sad_valid
    );
endinterface

// File: rtl/sad_absdiff_accumulator.sv
// Sum of absolute differences over blocks of N_PAIRS pixel pairs: a registered |a-b| stage feeds
// an accumulator, and the completed sum is held until the consumer takes it.
module sad_absdiff_accumulator #(
    parameter int unsigned N_PAIRS = 16,
    parameter int unsigned ACC_W   = 8 + $clog2(N_PAIRS)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      clear,
    sad_absdiff_accumulator_if.slave  bus
);

    localparam int unsigned CntW = $clog2(N_PAIRS);
    localparam logic [CntW-1:0] CntMax = CntW'(N_PAIRS - 1);

    typedef enum logic [1:0] {StAcc, StDrain, StHold} state_e;

    // Returns {carry_out, x - y} from x + ~y + 1, carries from a Sklansky prefix tree.
    function automatic logic [8:0] sub_sklansky(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] yn, g, p, gg, pp, c;
        int         j;
        yn = ~y;
        g  = x & yn;
        p  = x ^ yn;
        gg = g;
        pp = p;
        gg[0] = g[0] | p[0];
        for (int lvl = 0; lvl < 3; lvl++) begin
            for (int i = 0; i < 8; i++) begin
                if (((i >> lvl) & 1) == 1) begin
                    j = ((i >> lvl) << lvl) - 1;
                    gg[i] = gg[i] | (pp[i] & gg[j]);
                    pp[i] = pp[i] & pp[j];
                end
            end
        end
        c = {gg[6:0], 1'b1};
        return {gg[7], p ^ c};
    endfunction

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       diff_q, diff_d;
    logic             diff_v_q, diff_v_d;
    logic [ACC_W-1:0] sad_q, sad_d;
    logic             sad_valid_q, sad_valid_d;

    logic [8:0]       sub_res;
    logic [7:0]       abs_diff;
    logic             in_ready;
    logic             accept;

    always_comb begin
        sub_res  = sub_sklansky(bus.a, bus.b);
        // No carry out means a borrow: a < b, so negate the wrapped difference.
        abs_diff = sub_res[8] ? sub_res[7:0] : (~sub_res[7:0] + 8'd1);
        in_ready = enable & reset_n & (state_q == StAcc) & ~clear;
        accept   = in_ready & bus.in_valid;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        diff_d      = diff_q;
        diff_v_d    = diff_v_q;
        sad_d       = sad_q;
        sad_valid_d = sad_valid_q;

        if (enable) begin
            // A completed result in HOLD survives clear.
            if (clear && (state_q != StHold)) begin
                state_d  = StAcc;
                cnt_d    = '0;
                acc_d    = '0;
                diff_v_d = 1'b0;
            end else begin
                unique case (state_q)
                    StAcc: begin
                        if (diff_v_q) begin
                            acc_d = acc_q + ACC_W'(diff_q);
                        end
                        diff_v_d = accept;
                        if (accept) begin
                            diff_d = abs_diff;
                            if (cnt_q == CntMax) begin
                                cnt_d   = '0;
                                state_d = StDrain;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                    end
                    StDrain: begin
                        sad_d       = acc_q + (diff_v_q ? ACC_W'(diff_q) : '0);
                        sad_valid_d = 1'b1;
                        acc_d       = '0;
                        diff_v_d    = 1'b0;
                        state_d     = StHold;
                    end
                    StHold: begin
                        if (bus.sad_ready) begin
                            sad_valid_d = 1'b0;
                            state_d     = StAcc;
                        end
                    end
                    default: state_d = StAcc;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= StAcc;
            cnt_q       <= '0;
            acc_q       <= '0;
            diff_q      <= '0;
            diff_v_q    <= 1'b0;
            sad_q       <= '0;
            sad_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            diff_q      <= diff_d;
            diff_v_q    <= diff_v_d;
            sad_q       <= sad_d;
            sad_valid_q <= sad_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.sad       = sad_q;
    assign bus.sad_valid = sad_valid_q;

endmodule
